rst_seq_ctrl: RTL and testbench

- Parametrised reset sequencer and clock-enable generator. It replaces the fixed single reset/clock-delay pattern used in bench tops with a synthesizable block.
- Drives NUM_CH independent active-high reset outputs. Each output is released a programmable number of cycles after global reset is removed.
- Supports a software-triggered re-reset.
- Generates a divided clock-enable pulse once the sequence completes.
- Sits between the top-level clock/reset source and DUT sub-blocks in both bench tops and RTL integration.

---
 rtl/rst_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: releases NUM_CH reset outputs at programmable delays after global reset,
// supports software re-reset with a hold window, and emits a divided clock enable once done.
module rst_seq_ctrl #(
  parameter int NUM_CH   = 4,
  parameter int DLY_W    = 8,
  parameter int HOLD_CYC = 16,
  parameter int DIV_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*DLY_W-1:0] dly_cfg,
  input  logic                    sw_rst_req,
  input  logic [DIV_W-1:0]        div_cfg,
  output logic [NUM_CH-1:0]       ch_rst_o,
  output logic                    done_o,
  output logic                    busy_o,
  output logic                    clk_en_o
);

  localparam int                HOLD_W    = $clog2(HOLD_CYC + 1);
  localparam logic [DLY_W-1:0]  CNT_MAX   = '1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    S_RESET,
    S_COUNT,
    S_HOLD,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [1:0]              sync_q, sync_d;
  logic [NUM_CH*DLY_W-1:0] dly_q, dly_d;
  logic [DLY_W-1:0]        cnt_q, cnt_d;
  logic [HOLD_W-1:0]       hold_q, hold_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [NUM_CH-1:0]       ch_rst_q, ch_rst_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic                    clk_en_q, clk_en_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_RESET;
      sync_q   <= '0;
      dly_q    <= '0;
      cnt_q    <= '0;
      hold_q   <= '0;
      div_q    <= '0;
      ch_rst_q <= '1;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      clk_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      dly_q    <= dly_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      div_q    <= div_d;
      ch_rst_q <= ch_rst_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      clk_en_q <= clk_en_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sync_d   = {sync_q[0], 1'b1};
    dly_d    = dly_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    ch_rst_d = ch_rst_q;
    div_d    = '0;
    clk_en_d = 1'b0;

    unique case (state_q)
      // Leave RESET on the cycle the first sync stage is set but the second is not yet
      S_RESET: begin
        if (sync_q[0] && !sync_q[1]) begin
          state_d = S_COUNT;
          dly_d   = dly_cfg;
          cnt_d   = '0;
        end
      end
      S_COUNT: begin
        if (sw_rst_req) begin
          state_d  = S_HOLD;
          hold_d   = '0;
          ch_rst_d = '1;
        end else begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (cnt_q == dly_q[i*DLY_W +: DLY_W]) ch_rst_d[i] = 1'b0;
          end
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          if (ch_rst_q == '0) state_d = S_DONE;
        end
      end
      S_HOLD: begin
        if (sw_rst_req) begin
          hold_d = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d = S_COUNT;
          dly_d   = dly_cfg;
          cnt_d   = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_DONE: begin
        if (sw_rst_req) begin
          state_d  = S_HOLD;
          hold_d   = '0;
          ch_rst_d = '1;
        end
      end
      default: state_d = S_RESET;
    endcase

    busy_d = (state_d == S_COUNT) || (state_d == S_HOLD);
    done_d = (state_d == S_DONE);

    // Divider compares against the live div_cfg so a shrinking value wraps immediately
    if (done_d) begin
      if (div_q >= div_cfg) begin
        clk_en_d = 1'b1;
        div_d    = '0;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  assign ch_rst_o = ch_rst_q;
  assign done_o   = done_q;
  assign busy_o   = busy_q;
  assign clk_en_o = clk_en_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: stimulus pushes model predictions per edge,
// a monitor pops and compares them after each rising edge.
module tb_rst_seq_ctrl;

  localparam int NUM_CH   = 4;
  localparam int DLY_W    = 8;
  localparam int HOLD_CYC = 16;
  localparam int DIV_W    = 8;
  localparam int CFG_W    = NUM_CH * DLY_W;
  localparam int OUT_W    = NUM_CH + 3;

  logic              clk;
  logic              rst;
  logic [CFG_W-1:0]  dly_cfg;
  logic              sw_rst_req;
  logic [DIV_W-1:0]  div_cfg;
  logic [NUM_CH-1:0] ch_rst_o;
  logic              done_o;
  logic              busy_o;
  logic              clk_en_o;

  rst_seq_ctrl #(
    .NUM_CH  (NUM_CH),
    .DLY_W   (DLY_W),
    .HOLD_CYC(HOLD_CYC),
    .DIV_W   (DIV_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .dly_cfg   (dly_cfg),
    .sw_rst_req(sw_rst_req),
    .div_cfg   (div_cfg),
    .ch_rst_o  (ch_rst_o),
    .done_o    (done_o),
    .busy_o    (busy_o),
    .clk_en_o  (clk_en_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int               cyc;
    logic [OUT_W-1:0] val;
    string            tag;
  } exp_t;

  exp_t exp_q[$];
  int   cyc_cnt = 0;
  int   checks  = 0;
  int   errors  = 0;

  logic [CFG_W-1:0] cur_cfg;
  int               cur_div;

  // Reference model: everything is expressed as edge distances from the start of a sequence
  bit m_in_reset = 1'b1;
  int m_rel      = 0;
  bit m_in_hold  = 1'b0;
  int m_hold_start;
  int m_seq_start;
  int m_dly[NUM_CH];
  int m_max;
  bit m_done_seen;
  int m_last;

  function automatic void start_seq(input int c, input logic [CFG_W-1:0] cfg);
    m_in_reset  = 1'b0;
    m_in_hold   = 1'b0;
    m_seq_start = c;
    m_max       = 0;
    m_done_seen = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_dly[i] = int'(cfg[i*DLY_W +: DLY_W]);
      if (m_dly[i] > m_max) m_max = m_dly[i];
    end
  endfunction

  function automatic logic [OUT_W-1:0] model_edge(input int c, input bit r,
                                                  input logic [CFG_W-1:0] cfg,
                                                  input bit sw, input int div);
    logic [NUM_CH-1:0] ch;
    bit dn, bs, ce;
    int t;
    ch = '1; dn = 1'b0; bs = 1'b0; ce = 1'b0;
    if (r) begin
      m_in_reset = 1'b1;
      m_rel      = 0;
      m_in_hold  = 1'b0;
    end else if (m_in_reset) begin
      if (m_rel >= 1) start_seq(c, cfg);
      else m_rel++;
    end else if (m_in_hold) begin
      if (sw) m_hold_start = c;
      else if (c - m_hold_start == HOLD_CYC) start_seq(c, cfg);
    end else if (sw) begin
      m_in_hold    = 1'b1;
      m_hold_start = c;
    end

    if (m_in_hold) begin
      bs = 1'b1;
    end else if (!m_in_reset) begin
      t = c - m_seq_start;
      for (int i = 0; i < NUM_CH; i++) ch[i] = (t < 1 + m_dly[i]);
      dn = (t >= 2 + m_max);
      bs = !dn;
      if (dn) begin
        if (!m_done_seen) begin
          m_done_seen = 1'b1;
          m_last      = c - 1;
        end
        if (c - m_last >= div + 1) begin
          ce     = 1'b1;
          m_last = c;
        end
      end
    end
    return {ch, dn, bs, ce};
  endfunction

  function automatic logic [CFG_W-1:0] pack4(input int d3, input int d2, input int d1, input int d0);
    return {DLY_W'(d3), DLY_W'(d2), DLY_W'(d1), DLY_W'(d0)};
  endfunction

  function automatic logic [CFG_W-1:0] rand_cfg();
    logic [CFG_W-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[i*DLY_W +: DLY_W] = DLY_W'($urandom_range(0, 20));
    return v;
  endfunction

  task automatic applyStimulus(input bit r, input logic [CFG_W-1:0] cfg, input bit sw,
                               input int div, input string tag);
    exp_t e;
    @(negedge clk);
    rst        = r;
    dly_cfg    = cfg;
    sw_rst_req = sw;
    div_cfg    = DIV_W'(div);
    e.cyc = cyc_cnt + 1;
    e.val = model_edge(e.cyc, r, cfg, sw, div);
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic run(input int n, input string tag);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, cur_cfg, 1'b0, cur_div, tag);
  endtask

  task automatic checkOutput(input logic [OUT_W-1:0] req, input string tag, input int cyc);
    logic [OUT_W-1:0] act;
    act = {ch_rst_o, done_o, busy_o, clk_en_o};
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d actual ch=%b done=%b busy=%b clk_en=%b required ch=%b done=%b busy=%b clk_en=%b",
               tag, cyc, act[OUT_W-1:3], act[2], act[1], act[0],
               req[OUT_W-1:3], req[2], req[1], req[0]);
    end
  endtask

  always @(posedge clk) begin : monitor
    exp_t e;
    cyc_cnt++;
    #1;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
      e = exp_q.pop_front();
      if (e.cyc < cyc_cnt) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s stale expectation cyc=%0d actual now=%0d", e.tag, e.cyc, cyc_cnt);
      end else begin
        checkOutput(e.val, e.tag, e.cyc);
      end
    end
  end

  initial begin : stim
    bit sw_r;
    rst        = 1'b0;
    dly_cfg    = '0;
    sw_rst_req = 1'b0;
    div_cfg    = '0;
    cur_cfg    = pack4(10, 0, 5, 3);
    cur_div    = 3;
    #1 rst = 1'b1;
    #1 checkOutput({4'b1111, 3'b000}, "por_async", cyc_cnt);

    // Power-on sequence with sw_rst_req held high through RESET
    repeat (3) applyStimulus(1'b1, cur_cfg, 1'b1, cur_div, "por_reset");
    repeat (2) applyStimulus(1'b0, cur_cfg, 1'b1, cur_div, "por_sw_ignored");
    run(20, "por_seq");

    // Asynchronous reset in the middle of COUNT, then replay
    applyStimulus(1'b1, cur_cfg, 1'b0, cur_div, "abort_pre");
    run(5, "abort_count");
    @(posedge clk);
    #3 rst = 1'b1;
    #1 checkOutput({4'b1111, 3'b000}, "abort_async", cyc_cnt);
    repeat (2) applyStimulus(1'b1, cur_cfg, 1'b0, cur_div, "abort_hold");
    run(16, "abort_replay");

    // Software re-reset from DONE, new cfg during HOLD, hold restart at hold count 10
    applyStimulus(1'b0, cur_cfg, 1'b1, cur_div, "sw_from_done");
    for (int k = 1; k <= 10; k++) begin
      if (k == 3) cur_cfg = pack4(2, 7, 0, 4);
      applyStimulus(1'b0, cur_cfg, 1'b0, cur_div, "sw_hold");
    end
    applyStimulus(1'b0, cur_cfg, 1'b1, cur_div, "sw_hold_restart");
    run(30, "sw_rerun");

    // All-zero delays, then divider shrinking from 7 to 2 while the counter sits at 5
    cur_cfg = '0;
    cur_div = 7;
    applyStimulus(1'b1, cur_cfg, 1'b0, cur_div, "zero_reset");
    run(16, "zero_div7");
    cur_div = 2;
    run(8, "div_shrink");
    cur_div = 0;
    run(5, "div_zero");

    // Saturating delay of 255
    cur_cfg = pack4(255, 0, 1, 2);
    applyStimulus(1'b1, cur_cfg, 1'b0, cur_div, "sat_reset");
    run(262, "sat_seq");

    // Randomized segments
    for (int seg = 0; seg < 40; seg++) begin
      if ($urandom_range(0, 3) == 0) applyStimulus(1'b1, cur_cfg, 1'b0, cur_div, "rand_rst");
      cur_cfg = rand_cfg();
      for (int k = 0; k < 60; k++) begin
        sw_r = ($urandom_range(0, 24) == 0);
        if ($urandom_range(0, 15) == 0) cur_div = $urandom_range(0, 6);
        if ($urandom_range(0, 9) == 0) cur_cfg = rand_cfg();
        applyStimulus(1'b0, cur_cfg, sw_r, cur_div, "random");
      end
    end

    repeat (2) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain actual pending=%0d required pending=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
